// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one byte with inhibit/RTS, device-clocked shifting and ACK check.
module ps2_host_tx #(
  parameter int CLK_FREQ       = 50000000,
  parameter int INHIBIT_CYCLES = CLK_FREQ / 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 66
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    RECOVER
  } state_t;

  state_t        state;
  logic          clk_s1;
  logic          clk_s2;
  logic          data_s1;
  logic          data_s2;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic [7:0]    data_q;
  logic          par_q;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] wd_cnt;
  logic          ok;
  logic          wd_hit;

  assign wd_hit = (wd_cnt == T_LAST);

  // Synchronize both lines and debounce the clock into fclk / fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      fclk    <= 1'b1;
      fcnt    <= '0;
      fall    <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 == fclk) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        fclk <= clk_s2;
        fcnt <= '0;
        fall <= fclk;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Frame sequencer with registered line drives and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      par_q       <= 1'b0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      ok          <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            data_q   <= tx_data;
            par_q    <= ~^tx_data;
            inh_cnt  <= '0;
            wd_cnt   <= '0;
            bit_idx  <= '0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          ps2_clk_oe <= 1'b1;
          if (inh_cnt == I_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        START: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b1;
          bit_idx     <= '0;
          wd_cnt      <= '0;
          state       <= SEND;
        end
        SEND: begin
          if (fall) begin
            wd_cnt  <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx < 4'd8) begin
              ps2_data_oe <= ~data_q[bit_idx[2:0]];
            end else if (bit_idx == 4'd8) begin
              ps2_data_oe <= ~par_q;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end else if (wd_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            wd_cnt <= '0;
            ok     <= ~data_s2;
            state  <= RECOVER;
          end else if (wd_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (fclk && data_s2) begin
            tx_done  <= ok;
            tx_error <= ~ok;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else if (fall) begin
            wd_cnt <= '0;
          end else if (wd_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
